// File: rtl/audio_delay_tap.sv
// Single-tap feedforward echo: y[n] = sat(x[n] + (x[n-D] >>> fb_shift)) over a 2^ADDR_W circular buffer.
// A PRIME phase masks the tap until D samples have been written since the last delay change or reset.
module audio_delay_tap #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic        [ADDR_W-1:0] delay,
    input  logic        [1:0]        fb_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_sample,
    output logic        [ADDR_W:0]   fill_level,
    output logic                     dbg_state
);
    typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_W:0]          FILL_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]          FILL_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]        PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic signed [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        wr_ptr, d_lat, rd_idx;
    logic [ADDR_W:0]          fill_d;
    logic signed [DATA_W-1:0] mem [1<<ADDR_W];
    logic                     accept, delay_chg, use_tap;
    logic signed [DATA_W-1:0] tap, tap_sh, y;
    logic signed [DATA_W:0]   sum;

    // Handshake: a transfer happens on any edge where valid && ready; the output
    // register may be refilled in the same cycle it is drained.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign delay_chg = (delay != d_lat);
    assign rd_idx    = wr_ptr - delay;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_level;
        use_tap = 1'b0;
        if (accept) begin
            if (delay_chg)
                fill_d = FILL_ONE;
            else if (fill_level != FILL_MAX)
                fill_d = fill_level + FILL_ONE;
            use_tap = (state_q == RUN) && !delay_chg && (delay != '0);
            if (delay == '0)
                state_d = RUN;
            else if (delay_chg || state_q == PRIME)
                state_d = (fill_d >= {1'b0, delay}) ? RUN : PRIME;
        end
    end

    // Tap read sees the old buffer contents, i.e. before this cycle's write.
    always_comb begin
        tap    = use_tap ? mem[rd_idx] : '0;
        tap_sh = tap >>> fb_shift;
        sum    = {in_sample[DATA_W-1], in_sample} + {tap_sh[DATA_W-1], tap_sh};
        if (sum[DATA_W] != sum[DATA_W-1])
            y = sum[DATA_W] ? SAT_MIN : SAT_MAX;
        else
            y = sum[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PRIME;
            wr_ptr     <= '0;
            d_lat      <= '0;
            fill_level <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            state_q    <= state_d;
            fill_level <= fill_d;
            if (accept) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                d_lat      <= delay;
                out_valid  <= 1'b1;
                out_sample <= y;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Left unreset so it maps onto RAM; PRIME keeps stale entries off the output.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in_sample;
    end
endmodule

// File: tb/tb_audio_delay_tap.sv
// Directed bench for audio_delay_tap: vector table for streaming cases, hand sequences
// for wrap-around, backpressure and asynchronous reset.
module tb_audio_delay_tap;
    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_sample;
    logic        [3:0] delay;
    logic        [1:0] fb_shift;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_sample;
    logic        [4:0] fill_level;
    logic              dbg_state;

    int tests;
    int failed;

    localparam logic ST_PRIME = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    typedef struct {
        logic              rst_before;
        logic signed [7:0] x;
        logic        [3:0] d;
        logic        [1:0] fb;
        logic signed [7:0] y;
        logic        [4:0] fill;
        logic              st;
    } vec_t;

    vec_t vecs[$];

    audio_delay_tap #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .delay     (delay),
        .fb_shift  (fb_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sample(out_sample),
        .fill_level(fill_level),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input int rb, input int x, input int d, input int fb,
                           input int y, input int fill, input logic st);
        vec_t v;
        v.rst_before = (rb != 0);
        v.x    = 8'(x);
        v.d    = 4'(d);
        v.fb   = 2'(fb);
        v.y    = 8'(y);
        v.fill = 5'(fill);
        v.st   = st;
        vecs.push_back(v);
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one sample with out_ready=1; returns 1 unit after the accepting edge.
    task automatic push(input int x, input int d, input int fb);
        in_valid  = 1'b1;
        in_sample = 8'(x);
        delay     = 4'(d);
        fb_shift  = 2'(fb);
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_out(input string name, input int y, input int fill);
        check({name, " out_valid"}, 32'(out_valid), 1);
        check({name, " out_sample"}, 32'(out_sample), y);
        check({name, " fill_level"}, 32'(fill_level), fill);
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        delay     = '0;
        fb_shift  = '0;
        out_ready = 1'b1;

        #1;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_sample", 32'(out_sample), 0);
        check("reset fill_level", 32'(fill_level), 0);
        check("reset state", 32'(dbg_state), 32'(ST_PRIME));
        check("reset in_ready", 32'(in_ready), 1);

        // D=3 basic echo: RUN after the third accept
        add_vec(1, 10, 3, 0, 10, 1, ST_PRIME);
        add_vec(0, 20, 3, 0, 20, 2, ST_PRIME);
        add_vec(0, 30, 3, 0, 30, 3, ST_RUN);
        add_vec(0, 40, 3, 0, 50, 4, ST_RUN);
        add_vec(0, 50, 3, 0, 70, 5, ST_RUN);
        // D=2, fb_shift=1: positive then negative saturation
        add_vec(1, 100, 2, 1, 100, 1, ST_PRIME);
        add_vec(0, 100, 2, 1, 100, 2, ST_RUN);
        add_vec(0, 100, 2, 1, 127, 3, ST_RUN);
        add_vec(0, -100, 2, 1, -50, 4, ST_RUN);
        add_vec(0, -100, 2, 1, -50, 5, ST_RUN);
        add_vec(0, -100, 2, 1, -128, 6, ST_RUN);
        // delay change 3 -> 5 mid-stream re-primes
        add_vec(1, 1, 3, 0, 1, 1, ST_PRIME);
        add_vec(0, 2, 3, 0, 2, 2, ST_PRIME);
        add_vec(0, 3, 3, 0, 3, 3, ST_RUN);
        add_vec(0, 4, 3, 0, 5, 4, ST_RUN);
        add_vec(0, 10, 5, 0, 10, 1, ST_PRIME);
        add_vec(0, 20, 5, 0, 20, 2, ST_PRIME);
        add_vec(0, 30, 5, 0, 30, 3, ST_PRIME);
        add_vec(0, 40, 5, 0, 40, 4, ST_PRIME);
        add_vec(0, 50, 5, 0, 50, 5, ST_RUN);
        add_vec(0, 60, 5, 0, 70, 6, ST_RUN);
        add_vec(0, 70, 5, 0, 90, 7, ST_RUN);
        // D=1 with varying fb_shift, sampled per accept
        add_vec(1, 40, 1, 0, 40, 1, ST_RUN);
        add_vec(0, 8, 1, 2, 18, 2, ST_RUN);
        add_vec(0, -7, 1, 3, -6, 3, ST_RUN);
        add_vec(0, 0, 1, 0, -7, 4, ST_RUN);
        // D=0 bypass
        add_vec(1, 55, 0, 0, 55, 1, ST_RUN);
        add_vec(0, -3, 0, 0, -3, 2, ST_RUN);
        add_vec(0, 127, 0, 3, 127, 3, ST_RUN);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before)
                do_reset();
            push(32'(vecs[i].x), 32'(vecs[i].d), 32'(vecs[i].fb));
            check_out($sformatf("vec%0d", i), 32'(vecs[i].y), 32'(vecs[i].fill));
            check($sformatf("vec%0d state", i), 32'(dbg_state), 32'(vecs[i].st));
        end

        // D=15 over 20 samples: pointer wraps, fill saturates at 16
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            push(k, 15, 0);
            check_out($sformatf("wrap k=%0d", k), (k >= 16) ? (k + (k - 15)) : k, (k >= 16) ? 16 : k);
        end

        // Backpressure: stall for 4 cycles with a pending sample
        do_reset();
        push(1, 2, 0);
        push(2, 2, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain out_valid", 32'(out_valid), 0);
        check("drain out_sample held", 32'(out_sample), 2);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sample = 8'sd3;
        @(posedge clk);
        #1;
        check_out("stall first", 4, 3);
        in_sample = 8'sd4;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall%0d in_ready", c), 32'(in_ready), 0);
            @(posedge clk);
            #1;
            check_out($sformatf("stall%0d", c), 4, 3);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_out("release", 6, 4);
        push(5, 2, 0);
        check_out("after release", 8, 5);

        // Asynchronous reset between edges drops the held result
        do_reset();
        push(7, 2, 0);
        out_ready = 1'b0;
        #2;
        check("pre-rst out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 0);
        check("async rst out_sample", 32'(out_sample), 0);
        check("async rst fill_level", 32'(fill_level), 0);
        check("async rst state", 32'(dbg_state), 32'(ST_PRIME));
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        push(9, 2, 0);
        check_out("post-rst first", 9, 1);
        push(11, 2, 0);
        check_out("post-rst second", 11, 2);
        push(13, 2, 0);
        check_out("post-rst third", 22, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/audio_delay_tap.md
AUDIO_DELAY_TAP -- requirements
Module: audio_delay_tap

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning sample width (two's complement).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning log2 of delay-line depth (16 entries).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream sample present.
REQ-006 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-007 SHALL have port in_sample  input  DATA_W  signed input sample x[n].
REQ-008 SHALL have port delay  input  ADDR_W  echo delay D, in samples.
REQ-009 SHALL have port fb_shift  input  2  echo attenuation; tap scaled by arithmetic right shift of fb_shift.
REQ-010 SHALL have port out_valid  output  1  out_sample holds a result.
REQ-011 SHALL have port out_ready  input  1  downstream (processor/RAM writer) takes result.
REQ-012 SHALL have port out_sample  output  DATA_W  signed result y[n].
REQ-013 SHALL have port fill_level  output  ADDR_W+1  samples written since last prime, saturating at 2^ADDR_W.

Function
REQ-014 SHALL accept a sample when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-015 SHALL hold an internal 2^ADDR_W x DATA_W circular buffer plus write pointer wr_ptr.
REQ-016 On accept: buf[wr_ptr] <= x[n]; wr_ptr <= wr_ptr + 1, wrapping 2^ADDR_W-1 -> 0.
REQ-017 Delayed tap SHALL be buf[wr_ptr - D] (mod 2^ADDR_W), read before the same-cycle write, i.e. x[n-D].
REQ-018 y[n] SHALL be x[n] + (tap >>> fb_shift), computed at DATA_W+1 bits, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-019 D = 0 SHALL mean bypass: y[n] = x[n], tap ignored.
REQ-020 Latency SHALL be one cycle: accepted sample's result appears on out_sample with out_valid=1 on the next edge.
REQ-021 out_sample/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-022 out_valid SHALL clear on a cycle with out_ready=1 and no new accept; accept with out_ready=1 SHALL replace the result with out_valid staying 1.
REQ-023 FSM states: PRIME, RUN.
REQ-024 PRIME: tap treated as 0; fill_level increments per accept; transition to RUN on the accept that makes fill_level = D_lat (latched delay).
REQ-025 RUN: tap used per REQ-017; fill_level keeps incrementing to saturation.
REQ-026 D_lat SHALL be captured on every accept; an accept with delay != D_lat SHALL enter PRIME, fill_level <= 1, and produce that sample's result with tap 0.
REQ-027 D = 0 latched SHALL go directly to RUN (nothing to prime).
REQ-028 fb_shift SHALL be sampled on accept only; changes need no re-prime.
REQ-029 Buffer contents SHALL NOT be cleared on re-prime; PRIME masking alone prevents stale taps.

Reset
REQ-030 rst=1 SHALL immediately force: state PRIME, wr_ptr 0, D_lat 0, fill_level 0, out_valid 0, out_sample 0.
REQ-031 Buffer memory need not be reset (RAM-inferable); PRIME guarantees no unreset data reaches out_sample.
REQ-032 Reset asserted mid-stream SHALL discard any held output; first post-reset accept behaves as first-ever sample.

Verification
REQ-033 D=3, fb_shift=0, out_ready=1, inputs 10,20,30,40,50 back-to-back -> outputs 10,20,30,50,70; RUN entered after 3rd accept.
REQ-034 D=2, fb_shift=1, inputs 100,100,100 -> outputs 100,100,127 (100+50 saturates); inputs -100,-100,-100 after prime -> -128 saturation seen.
REQ-035 D=15, 20 consecutive samples n=1..20 -> wr_ptr wraps; output k>=16 equals x[k]+x[k-15]; fill_level saturates at 16.
REQ-036 out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 after first accept, out_sample frozen, no buffer write; release -> stream continues, no sample lost or duplicated.
REQ-037 D changed 3->5 mid-stream -> that sample's output equals its input, fill_level=1, tap resumes after 5 samples.
REQ-038 rst pulse asynchronously between edges while out_valid=1 -> out_valid 0 immediately; next sample passes through unchanged (tap 0).
